// File: rtl/handball_pkg.sv
// Shared types and constants for the handball game blocks.
package handball_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TO_WALL,
    TO_PLAYER,
    MISSED
  } ball_state_t;

  localparam int unsigned DEFAULT_N_LEDS = 8;

endpackage

// File: rtl/shift_tick_sync.sv
// Brings the divided SHIFT_CLK level into the CLKIN domain and emits a registered
// one-cycle STEP per rising edge.
module shift_tick_sync (
  input  logic CLKIN,
  input  logic RST,
  input  logic SHIFT_CLK,
  output logic STEP
);

  logic sync1, sync2, prev;

  always_ff @(posedge CLKIN) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      STEP  <= 1'b0;
    end else begin
      sync1 <= SHIFT_CLK;
      sync2 <= sync1;
      prev  <= sync2;
      STEP  <= sync2 & ~prev;
    end
  end

endmodule

// File: rtl/ball_shifter.sv
// Handball ball mover: steps a one-hot ball along the LED row, bounces it at the wall,
// judges HIT presses and keeps the rally score. Option macro: BALL_SPEEDUP_EN.
module ball_shifter
  import handball_pkg::*;
#(
  parameter int unsigned N_LEDS     = DEFAULT_N_LEDS,
  parameter int unsigned SCORE_W    = 4,
  parameter int unsigned STEP_TICKS = 2
) (
  input  logic               CLKIN,
  input  logic               RST,
  input  logic               SHIFT_CLK,
  input  logic               SERVE,
  input  logic               HIT,
  output logic [N_LEDS-1:0]  LEDS,
  output logic [SCORE_W-1:0] SCORE,
  output logic               MISS,
  output logic               BUSY
);

  localparam int unsigned TW = $clog2(STEP_TICKS + 1);

  localparam logic [N_LEDS-1:0]  LED_SERVE  = N_LEDS'(1);
  localparam logic [N_LEDS-1:0]  LED_RETURN = N_LEDS'(2);
  localparam logic [N_LEDS-1:0]  LED_BOUNCE = N_LEDS'(1) << (N_LEDS - 2);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  ball_state_t   state;
  logic          step;
  logic          move;
  logic          serve_prev, hit_prev;
  logic          serve_press, hit_press;
  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] period;

  shift_tick_sync u_sync (
    .CLKIN     (CLKIN),
    .RST       (RST),
    .SHIFT_CLK (SHIFT_CLK),
    .STEP      (step)
  );

`ifndef BALL_SPEEDUP_EN
  assign period = TW'(STEP_TICKS);
`endif

  // prev flops reset high so a button held through reset is not a press
  assign serve_press = SERVE & ~serve_prev;
  assign hit_press   = HIT & ~hit_prev;
  assign move        = step && (tick_cnt == period - TW'(1));

  always_ff @(posedge CLKIN) begin
    if (RST) begin
      state      <= IDLE;
      LEDS       <= '0;
      SCORE      <= '0;
      MISS       <= 1'b0;
      BUSY       <= 1'b0;
      tick_cnt   <= '0;
      serve_prev <= 1'b1;
      hit_prev   <= 1'b1;
`ifdef BALL_SPEEDUP_EN
      period     <= TW'(STEP_TICKS);
`endif
    end else begin
      serve_prev <= SERVE;
      hit_prev   <= HIT;
      unique case (state)
        IDLE, MISSED: begin
          if (serve_press) begin
            state    <= TO_WALL;
            LEDS     <= LED_SERVE;
            SCORE    <= '0;
            MISS     <= 1'b0;
            BUSY     <= 1'b1;
            tick_cnt <= '0;
`ifdef BALL_SPEEDUP_EN
            period   <= TW'(STEP_TICKS);
`endif
          end
        end
        TO_WALL: begin
          if (move) begin
            tick_cnt <= '0;
            if (LEDS[N_LEDS-1]) begin
              LEDS  <= LED_BOUNCE;
              state <= TO_PLAYER;
            end else begin
              LEDS <= LEDS << 1;
            end
          end else if (step) begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        TO_PLAYER: begin
          // a return beats a simultaneous move off the player end
          if (hit_press && LEDS[0]) begin
            state    <= TO_WALL;
            LEDS     <= LED_RETURN;
            tick_cnt <= '0;
            if (SCORE != SCORE_MAX) SCORE <= SCORE + SCORE_W'(1);
`ifdef BALL_SPEEDUP_EN
            if (period > TW'(1)) period <= period - TW'(1);
`endif
          end else if (move) begin
            tick_cnt <= '0;
            if (LEDS[0]) begin
              state <= MISSED;
              LEDS  <= '0;
              MISS  <= 1'b1;
              BUSY  <= 1'b0;
            end else begin
              LEDS <= LEDS >> 1;
            end
          end else if (step) begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_shifter.sv
// Randomised self-checking bench for ball_shifter against a ball-position reference model.
module tb_ball_shifter;

  localparam int N  = 8;
  localparam int SW = 4;
  localparam int ST = 2;

  logic          CLKIN = 1'b0;
  logic          RST, SHIFT_CLK, SERVE, HIT;
  logic [N-1:0]  LEDS;
  logic [SW-1:0] SCORE;
  logic          MISS, BUSY;

  ball_shifter #(.N_LEDS(N), .SCORE_W(SW), .STEP_TICKS(ST)) u_dut (
    .CLKIN     (CLKIN),
    .RST       (RST),
    .SHIFT_CLK (SHIFT_CLK),
    .SERVE     (SERVE),
    .HIT       (HIT),
    .LEDS      (LEDS),
    .SCORE     (SCORE),
    .MISS      (MISS),
    .BUSY      (BUSY)
  );

  always #5 CLKIN = ~CLKIN;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: ball position as an integer, direction as a state number
  // (0 idle, 1 to wall, 2 to player, 3 missed).
  int       m_state, m_pos, m_score, m_tick, m_period, m_returns;
  bit       m_miss, sprev, hprev, step_vis;
  bit [3:0] h;
  bit       step_now, sp, hp, mv;

  always @(posedge CLKIN) begin
    if (RST) begin
      m_state = 0; m_pos = -1; m_score = 0; m_miss = 0; m_tick = 0; m_period = ST;
      sprev = 1; hprev = 1; h = '0; step_vis = 0;
    end else begin
      // STEP appears three edges after SHIFT_CLK is first seen high
      step_now = step_vis;
      step_vis = h[1] & ~h[2];
      h = {h[2:0], SHIFT_CLK};
      sp = SERVE && !sprev;
      hp = HIT && !hprev;
      sprev = SERVE;
      hprev = HIT;
      mv = step_now && (m_tick == m_period - 1);
      case (m_state)
        0, 3: if (sp) begin
          m_state = 1; m_pos = 0; m_score = 0; m_miss = 0; m_tick = 0; m_period = ST;
        end
        1: if (step_now) begin
          if (mv) begin
            m_tick = 0;
            if (m_pos == N - 1) begin m_pos = N - 2; m_state = 2; end
            else m_pos++;
          end else m_tick++;
        end
        default: begin
          if (hp && m_pos == 0) begin
            m_pos = 1; m_tick = 0; m_state = 1; m_returns++;
            m_score = (m_score < (1 << SW) - 1) ? m_score + 1 : m_score;
`ifdef BALL_SPEEDUP_EN
            m_period = (m_period > 1) ? m_period - 1 : 1;
`endif
          end else if (step_now) begin
            if (mv) begin
              m_tick = 0;
              if (m_pos == 0) begin m_state = 3; m_pos = -1; m_miss = 1; end
              else m_pos--;
            end else m_tick++;
          end
        end
      endcase
    end
    #2;
    check_val("leds",  LEDS,  (m_pos >= 0) ? (32'd1 << m_pos) : 32'd0);
    check_val("score", SCORE, m_score);
    check_val("miss",  MISS,  m_miss);
    check_val("busy",  BUSY,  (m_state == 1 || m_state == 2));
    check_val("step",  u_dut.step, step_vis);
  end

  bit free_run = 0;
  int phase    = 0;
  bit auto_hit = 0;

  task automatic cyc();
    @(negedge CLKIN);
    phase++;
    if (free_run) SHIFT_CLK = (phase % 40) < 20;
    if (auto_hit) HIT = (m_state == 2 && m_pos == 0 && !HIT);
  endtask

  task automatic serve();
    SERVE = 0; cyc();
    SERVE = 1; cyc();
    SERVE = 0; cyc();
  endtask

  initial begin
    RST = 1; SERVE = 1; HIT = 0; SHIFT_CLK = 0; m_returns = 0;
    repeat (3) cyc();
    RST = 0;
    repeat (5) cyc();
    check_val("held_serve_no_start", BUSY, 0);

    // single manual SHIFT_CLK pulse: one STEP on the rise, none on the fall
    SHIFT_CLK = 1;
    repeat (10) cyc();
    SHIFT_CLK = 0;
    repeat (10) cyc();

    // rally with no HIT ends in a miss
    free_run = 1;
    serve();
    for (int i = 0; i < 4000 && !m_miss; i++) cyc();
    cyc();
    check_val("miss_no_hit", MISS, 1);
    check_val("miss_leds", LEDS, 0);

    // returns until the score saturates, then let it miss
    serve();
    auto_hit = 1;
    for (int i = 0; i < 40000 && m_returns < 17; i++) cyc();
    cyc();
    check_val("score_saturated", SCORE, 15);
    auto_hit = 0; HIT = 0;
    for (int i = 0; i < 4000 && !m_miss; i++) cyc();
    cyc();
    check_val("miss_after_sat", MISS, 1);
    check_val("score_hold", SCORE, 15);

    // HIT with the ball at bit 2 is ignored
    serve();
    for (int i = 0; i < 4000 && !(m_state == 2 && m_pos == 2); i++) cyc();
    check_val("reach_04", LEDS, 8'h04);
    HIT = 1; cyc();
    HIT = 0;
    for (int i = 0; i < 4000 && !m_miss; i++) cyc();
    cyc();
    check_val("early_hit_ignored", MISS, 1);

    // reset mid-rally with SERVE held through it
    serve();
    for (int i = 0; i < 4000 && m_pos != 4; i++) cyc();
    check_val("reach_10", LEDS, 8'h10);
    RST = 1; SERVE = 1; cyc();
    RST = 0; cyc();
    check_val("rst_leds", LEDS, 0);
    check_val("rst_busy", BUSY, 0);
    repeat (5) cyc();
    check_val("held_after_rst", BUSY, 0);
    serve();
    check_val("serve_after_release", BUSY, 1);

    // random buttons and occasional reset
    for (int i = 0; i < 15000; i++) begin
      cyc();
      SERVE = ($urandom_range(0, 199) == 0);
      HIT   = ($urandom_range(0, 29) == 0);
      RST   = ($urandom_range(0, 4999) == 0);
    end
    RST = 0; SERVE = 0; HIT = 0;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
